progmem_fetch_master: RTL

PROGMEM_FETCH_MASTER -- requirements
Module: progmem_fetch_master

---
 rtl/progmem_fetch_master.sv | 132 +++++++++++++
 1 files changed

// File: rtl/progmem_fetch_master.sv
// Program-memory fetch master: streams `len` words from a wait-stalled read port
// into a small output FIFO, stopping early on an error response.
module progmem_fetch_master #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mst_address,
  output logic              mst_read,
  input  logic [31:0]       mst_readdata,
  input  logic [1:0]        mst_response,
  input  logic              mst_waitrequest,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        state_dbg
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, READ, HOLD, DRAIN, FIN} state_t;

  // Handshakes: master beat completes when mst_read && !mst_waitrequest;
  // output word transfers when out_valid && out_ready.
  state_t            state;
  logic [ADDR_W:0]   rem;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_after;
  logic              beat, beat_ok, beat_err, push, pop;

  assign beat        = (state == READ) && mst_read && !mst_waitrequest;
  assign beat_ok     = beat && (mst_response == 2'b00);
  assign beat_err    = beat && (mst_response != 2'b00);
  assign push        = beat_ok;
  assign pop         = out_valid && out_ready;
  assign count_after = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign out_valid   = (count != '0);
  assign out_data    = out_valid ? mem[rd_ptr] : '0;
  assign state_dbg   = state;

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mst_readdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      mst_address <= '0;
      mst_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      if (beat_err) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count_after;
      end

      case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
            busy  <= 1'b1;
            if (len != '0) begin
              mst_address <= base_addr;
              rem         <= len;
              mst_read    <= 1'b1;
              state       <= READ;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        READ: begin
          if (beat_err) begin
            error    <= 1'b1;
            mst_read <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end else if (beat_ok) begin
            mst_address <= mst_address + ADDR_W'(1);
            rem         <= rem - (ADDR_W+1)'(1);
            if (rem == (ADDR_W+1)'(1)) begin
              mst_read <= 1'b0;
              state    <= DRAIN;
            end else if (count_after == CW'(FIFO_DEPTH)) begin
              mst_read <= 1'b0;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (count < CW'(FIFO_DEPTH)) begin
            mst_read <= 1'b1;
            state    <= READ;
          end
        end
        DRAIN: begin
          if ((count == '0) || ((count == CW'(1)) && pop)) begin
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
